lvt_2w4r_read_select: RTL and testbench

//  Read-side output stage of the 2-write/4-read LVT register file. Consumes the

---
 rtl/lvt_2w4r_read_select.sv | 188 ++++++++++++++++++
 tb/tb_lvt_2w4r_read_select.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_2w4r_read_select.sv
// rtl/lvt_2w4r_read_select.sv - read-side output stage of the 2W/4R LVT register file
//
// Purpose:
//   Per read port, selects the bank that last wrote the address (via the
//   registered LVT entry) and registers the chosen word. With the
//   LVT_2W4R_BYPASS_EN macro defined, writes issued in the same cycle as a read
//   are forwarded over the stale read-before-write RAM data.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   we0/we1, write_addr_0/1       write-port enables and addresses (cycle T)
//   write_data_0/1                write-port data (cycle T, bypass build only)
//   read_addr_0..3, rd_req        read addresses and request qualifier (cycle T)
//   hold                          freeze output registers
//   lvt_0..3                      LVT entries (cycle T+1), 0 = bank 0, 1 = bank 1
//   b0_data_0..3, b1_data_0..3    bank read data (cycle T+1)
//   read_data_0..3, read_valid    selected operands (cycle T+2)
//
// Configuration:
//   LVT_2W4R_BYPASS_EN  defined: same-cycle write forwarding; undefined: pure LVT mux

module lvt_2w4r_read_select #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] write_addr_0,
  input  logic [ADDR_WIDTH-1:0] write_addr_1,
  input  logic [DATA_WIDTH-1:0] write_data_0,
  input  logic [DATA_WIDTH-1:0] write_data_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_0,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_3,
  input  logic                  rd_req,
  input  logic                  hold,
  input  logic                  lvt_0,
  input  logic                  lvt_1,
  input  logic                  lvt_2,
  input  logic                  lvt_3,
  input  logic [DATA_WIDTH-1:0] b0_data_0,
  input  logic [DATA_WIDTH-1:0] b0_data_1,
  input  logic [DATA_WIDTH-1:0] b0_data_2,
  input  logic [DATA_WIDTH-1:0] b0_data_3,
  input  logic [DATA_WIDTH-1:0] b1_data_0,
  input  logic [DATA_WIDTH-1:0] b1_data_1,
  input  logic [DATA_WIDTH-1:0] b1_data_2,
  input  logic [DATA_WIDTH-1:0] b1_data_3,
  output logic [DATA_WIDTH-1:0] read_data_0,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [DATA_WIDTH-1:0] read_data_3,
  output logic                  read_valid
);

  localparam int NUM_READ = 4;

  logic                  lvt_sel  [NUM_READ];
  logic [DATA_WIDTH-1:0] b0_data  [NUM_READ];
  logic [DATA_WIDTH-1:0] b1_data  [NUM_READ];
  logic [DATA_WIDTH-1:0] sel_data [NUM_READ];
  logic [DATA_WIDTH-1:0] out_q    [NUM_READ];
  logic                  rd_req_q;
  logic                  valid_q;

  assign lvt_sel[0] = lvt_0;
  assign lvt_sel[1] = lvt_1;
  assign lvt_sel[2] = lvt_2;
  assign lvt_sel[3] = lvt_3;

  assign b0_data[0] = b0_data_0;
  assign b0_data[1] = b0_data_1;
  assign b0_data[2] = b0_data_2;
  assign b0_data[3] = b0_data_3;

  assign b1_data[0] = b1_data_0;
  assign b1_data[1] = b1_data_1;
  assign b1_data[2] = b1_data_2;
  assign b1_data[3] = b1_data_3;

  assign read_data_0 = out_q[0];
  assign read_data_1 = out_q[1];
  assign read_data_2 = out_q[2];
  assign read_data_3 = out_q[3];
  assign read_valid  = valid_q;

  // Stage A: request qualifier. Keeps capturing during hold; the upstream is
  // responsible for stalling its own requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_req_q <= 1'b0;
    end else begin
      rd_req_q <= rd_req;
    end
  end

`ifdef LVT_2W4R_BYPASS_EN

  logic [ADDR_WIDTH-1:0] read_addr [NUM_READ];
  logic [ADDR_WIDTH-1:0] ra_q      [NUM_READ];
  logic                  we0_q;
  logic                  we1_q;
  logic [ADDR_WIDTH-1:0] wa0_q;
  logic [ADDR_WIDTH-1:0] wa1_q;
  logic [DATA_WIDTH-1:0] wd0_q;
  logic [DATA_WIDTH-1:0] wd1_q;

  assign read_addr[0] = read_addr_0;
  assign read_addr[1] = read_addr_1;
  assign read_addr[2] = read_addr_2;
  assign read_addr[3] = read_addr_3;

  // Stage A: the write that coincides with the read, so the mux stage can
  // recognise RAM data that is stale because of read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NUM_READ; n++) begin
        ra_q[n] <= '0;
      end
      we0_q <= 1'b0;
      we1_q <= 1'b0;
      wa0_q <= '0;
      wa1_q <= '0;
      wd0_q <= '0;
      wd1_q <= '0;
    end else begin
      for (int n = 0; n < NUM_READ; n++) begin
        ra_q[n] <= read_addr[n];
      end
      we0_q <= we0;
      we1_q <= we1;
      wa0_q <= write_addr_0;
      wa1_q <= write_addr_1;
      wd0_q <= write_data_0;
      wd1_q <= write_data_1;
    end
  end

  // Port 1 is checked first: when both write ports hit the same address the
  // LVT records bank 1, so forwarding must agree with it.
  always_comb begin
    for (int n = 0; n < NUM_READ; n++) begin
      sel_data[n] = lvt_sel[n] ? b1_data[n] : b0_data[n];
      if (we1_q && (wa1_q == ra_q[n])) begin
        sel_data[n] = wd1_q;
      end else if (we0_q && (wa0_q == ra_q[n])) begin
        sel_data[n] = wd0_q;
      end
    end
  end

`else

  // Without forwarding only the LVT mux remains; the write side and the read
  // addresses are not needed here and deliberately create no flops.
  logic unused_write_side;
  assign unused_write_side = ^{we0, we1, write_addr_0, write_addr_1,
                               write_data_0, write_data_1,
                               read_addr_0, read_addr_1, read_addr_2, read_addr_3};

  always_comb begin
    for (int n = 0; n < NUM_READ; n++) begin
      sel_data[n] = lvt_sel[n] ? b1_data[n] : b0_data[n];
    end
  end

`endif

  // Stage B: output registers. Reset takes priority over hold. Data updates
  // even when the captured request is low; read_valid marks it don't-care.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NUM_READ; n++) begin
        out_q[n] <= '0;
      end
      valid_q <= 1'b0;
    end else if (!hold) begin
      for (int n = 0; n < NUM_READ; n++) begin
        out_q[n] <= sel_data[n];
      end
      valid_q <= rd_req_q;
    end
  end

endmodule

// File: tb/tb_lvt_2w4r_read_select.sv
// tb/tb_lvt_2w4r_read_select.sv - self-checking bench for lvt_2w4r_read_select

module tb_lvt_2w4r_read_select;

`ifdef LVT_2W4R_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [3:0][4:0]  ra;
    logic             rd_req;
    logic             we0;
    logic             we1;
    logic [4:0]       wa0;
    logic [4:0]       wa1;
    logic [31:0]      wd0;
    logic [31:0]      wd1;
    logic [3:0]       lvt;
    logic [3:0][31:0] b0;
    logic [3:0][31:0] b1;
    logic [3:0][31:0] exp_d;
    logic             exp_v;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  write_addr_0, write_addr_1;
  logic [31:0] write_data_0, write_data_1;
  logic [4:0]  read_addr_0, read_addr_1, read_addr_2, read_addr_3;
  logic        rd_req, hold;
  logic        lvt_0, lvt_1, lvt_2, lvt_3;
  logic [31:0] b0_data_0, b0_data_1, b0_data_2, b0_data_3;
  logic [31:0] b1_data_0, b1_data_1, b1_data_2, b1_data_3;
  logic [31:0] read_data_0, read_data_1, read_data_2, read_data_3;
  logic        read_valid;

  int checks = 0;
  int errors = 0;

  vec_t vt[$];

  always #5 clock = ~clock;

  lvt_2w4r_read_select #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .we0(we0), .we1(we1),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_data_0(write_data_0), .write_data_1(write_data_1),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
    .read_addr_2(read_addr_2), .read_addr_3(read_addr_3),
    .rd_req(rd_req), .hold(hold),
    .lvt_0(lvt_0), .lvt_1(lvt_1), .lvt_2(lvt_2), .lvt_3(lvt_3),
    .b0_data_0(b0_data_0), .b0_data_1(b0_data_1), .b0_data_2(b0_data_2), .b0_data_3(b0_data_3),
    .b1_data_0(b1_data_0), .b1_data_1(b1_data_1), .b1_data_2(b1_data_2), .b1_data_3(b1_data_3),
    .read_data_0(read_data_0), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .read_data_3(read_data_3),
    .read_valid(read_valid)
  );

  function automatic vec_t idle_vec();
    vec_t v;
    v.ra = '0; v.rd_req = 1'b0; v.we0 = 1'b0; v.we1 = 1'b0;
    v.wa0 = '0; v.wa1 = '0; v.wd0 = '0; v.wd1 = '0;
    v.lvt = '0; v.b0 = '0; v.b1 = '0; v.exp_d = '0; v.exp_v = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0][31:0] all4(input logic [31:0] x);
    logic [3:0][31:0] r;
    for (int n = 0; n < 4; n++) r[n] = x;
    return r;
  endfunction

  task automatic drive_req(input vec_t v);
    read_addr_0 = v.ra[0]; read_addr_1 = v.ra[1];
    read_addr_2 = v.ra[2]; read_addr_3 = v.ra[3];
    rd_req = v.rd_req;
    we0 = v.we0; we1 = v.we1;
    write_addr_0 = v.wa0; write_addr_1 = v.wa1;
    write_data_0 = v.wd0; write_data_1 = v.wd1;
  endtask

  task automatic drive_bank(input vec_t v);
    lvt_0 = v.lvt[0]; lvt_1 = v.lvt[1]; lvt_2 = v.lvt[2]; lvt_3 = v.lvt[3];
    b0_data_0 = v.b0[0]; b0_data_1 = v.b0[1]; b0_data_2 = v.b0[2]; b0_data_3 = v.b0[3];
    b1_data_0 = v.b1[0]; b1_data_1 = v.b1[1]; b1_data_2 = v.b1[2]; b1_data_3 = v.b1[3];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0][31:0] exp_d, input logic exp_v);
    logic [3:0][31:0] act;
    act = {read_data_3, read_data_2, read_data_1, read_data_0};
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (act[n] !== exp_d[n]) begin
        errors++;
        $display("FAIL %s read_data_%0d got %h expected %h", name, n, act[n], exp_d[n]);
      end
    end
    checks++;
    if (read_valid !== exp_v) begin
      errors++;
      $display("FAIL %s read_valid got %b expected %b", name, read_valid, exp_v);
    end
  endtask

  task automatic check_valid(input string name, input logic exp_v);
    checks++;
    if (read_valid !== exp_v) begin
      errors++;
      $display("FAIL %s read_valid got %b expected %b", name, read_valid, exp_v);
    end
  endtask

  initial begin
    vec_t v;
    vec_t idle;

    // ---------------- vector table ----------------
    idle = idle_vec();

    // lvt all bank 0
    v = idle; v.ra = {5'd3, 5'd2, 5'd1, 5'd0}; v.rd_req = 1'b1;
    v.lvt = 4'b0000; v.b0 = all4(32'h1111_1111); v.b1 = all4(32'h2222_2222);
    v.exp_d = all4(32'h1111_1111); v.exp_v = 1'b1; vt.push_back(v);

    // lvt flips per port
    v.lvt = 4'b0101;
    v.exp_d = {32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
    vt.push_back(v);

    // rd_req low: data still updates, valid low
    v = idle; v.lvt = 4'b1111; v.b1 = all4(32'h3333_3333);
    v.exp_d = all4(32'h3333_3333); v.exp_v = 1'b0; vt.push_back(v);

    // same-cycle write to addr 5 read on port 2, banks stale 0
    v = idle; v.rd_req = 1'b1; v.ra = {5'd4, 5'd5, 5'd8, 5'd9};
    v.we0 = 1'b1; v.wa0 = 5'd5; v.wd0 = 32'hA5A5_0000;
    v.exp_d = {32'h0, BYP ? 32'hA5A5_0000 : 32'h0, 32'h0, 32'h0}; v.exp_v = 1'b1;
    vt.push_back(v);

    // next cycle: write now in the RAM, nothing to forward
    v = idle; v.rd_req = 1'b1; v.ra = {5'd4, 5'd5, 5'd8, 5'd9};
    v.b0 = {32'h0, 32'hA5A5_0000, 32'h0, 32'h0};
    v.exp_d = {32'h0, 32'hA5A5_0000, 32'h0, 32'h0}; v.exp_v = 1'b1;
    vt.push_back(v);

    // both ports write addr 7, all ports read addr 7
    v = idle; v.rd_req = 1'b1; v.ra = {5'd7, 5'd7, 5'd7, 5'd7};
    v.we0 = 1'b1; v.wa0 = 5'd7; v.wd0 = 32'h0000_0001;
    v.we1 = 1'b1; v.wa1 = 5'd7; v.wd1 = 32'h0000_0002;
    v.exp_d = all4(BYP ? 32'h0000_0002 : 32'h0); v.exp_v = 1'b1;
    vt.push_back(v);

    // independent writes to different addresses, mixed lvt
    v = idle; v.rd_req = 1'b1; v.ra = {5'd12, 5'd3, 5'd3, 5'd0};
    v.we1 = 1'b1; v.wa1 = 5'd3;  v.wd1 = 32'hCAFE_0003;
    v.we0 = 1'b1; v.wa0 = 5'd12; v.wd0 = 32'hBEEF_000C;
    v.lvt = 4'b0011; v.b0 = all4(32'h0000_00B0); v.b1 = all4(32'h0000_00B1);
    v.exp_d = BYP ? {32'hBEEF_000C, 32'hCAFE_0003, 32'hCAFE_0003, 32'h0000_00B1}
                  : {32'h0000_00B0, 32'h0000_00B0, 32'h0000_00B1, 32'h0000_00B1};
    v.exp_v = 1'b1; vt.push_back(v);

    // write enabled but address mismatch
    v = idle; v.rd_req = 1'b1; v.ra = {5'd1, 5'd1, 5'd1, 5'd1};
    v.we0 = 1'b1; v.wa0 = 5'd4; v.wd0 = 32'hDEAD_0004;
    v.lvt = 4'b1111; v.b1 = all4(32'h7777_7777);
    v.exp_d = all4(32'h7777_7777); v.exp_v = 1'b1; vt.push_back(v);

    // matching address but write disabled
    v = idle; v.rd_req = 1'b1; v.ra = {5'd2, 5'd2, 5'd2, 5'd2};
    v.we1 = 1'b0; v.wa1 = 5'd2; v.wd1 = 32'hFFFF_FFFF;
    v.we0 = 1'b0; v.wa0 = 5'd2; v.wd0 = 32'hEEEE_EEEE;
    v.b0 = all4(32'h1234_5678);
    v.exp_d = all4(32'h1234_5678); v.exp_v = 1'b1; vt.push_back(v);

    // ---------------- reset held 2 cycles, hold also asserted ----------------
    reset = 1'b1; hold = 1'b1;
    v = idle; v.rd_req = 1'b1; v.lvt = 4'b1111; v.b1 = all4(32'hFFFF_FFFF);
    drive_req(v); drive_bank(v);
    tick(); check_out("reset_c0", '0, 1'b0);
    tick(); check_out("reset_c1", '0, 1'b0);
    reset = 1'b0; hold = 1'b0;
    tick(); check_out("release_e0", all4(32'hFFFF_FFFF), 1'b0);
    tick(); check_valid("release_e1", 1'b1);

    // ---------------- table-driven stream ----------------
    for (int i = 0; i <= vt.size(); i++) begin
      if (i < vt.size()) drive_req(vt[i]);
      else drive_req(idle);
      if (i > 0) drive_bank(vt[i-1]);
      tick();
      if (i > 0) check_out($sformatf("vec%0d", i - 1), vt[i-1].exp_d, vt[i-1].exp_v);
    end

    // ---------------- hold mid-stream ----------------
    v = idle; v.rd_req = 1'b1;
    drive_req(v);
    v.b0 = all4(32'h0000_00FF); drive_bank(v);
    tick();
    for (int k = 0; k < 2; k++) begin
      v.b0 = all4(32'h0000_0100 + k); drive_bank(v);
      tick(); check_out($sformatf("pre_hold%0d", k), all4(32'h0000_0100 + k), 1'b1);
    end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v.rd_req = (k == 2) ? 1'b0 : 1'b1; drive_req(v);
      v.b0 = all4(32'h0000_0102 + k); drive_bank(v);
      tick(); check_out($sformatf("hold%0d", k), all4(32'h0000_0101), 1'b1);
    end
    hold = 1'b0;
    v.rd_req = 1'b1; drive_req(v);
    v.b0 = all4(32'h0000_0105); drive_bank(v);
    tick(); check_out("hold_release", all4(32'h0000_0105), 1'b0);
    v.b0 = all4(32'h0000_0106); drive_bank(v);
    tick(); check_out("post_release", all4(32'h0000_0106), 1'b1);

    // ---------------- reset beats hold ----------------
    reset = 1'b1; hold = 1'b1;
    tick(); check_out("reset_over_hold", '0, 1'b0);
    reset = 1'b0; hold = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
